// File: rtl/gnw_audio_mixer_if.sv
// Signal bundle between a sound-generating core and the audio mixer.
// The master drives the sound sources and controls; the slave returns the mixed samples.
interface gnw_audio_mixer_if #(
    parameter int CHANNELS = 1
);
    logic [CHANNELS-1:0] sound_in;
    logic                mute;
    logic [2:0]          atten;
    logic                signed_mode;
    logic [15:0]         audio_l;
    logic [15:0]         audio_r;
    logic                sample_strobe;
    logic [1:0]          ramp_state;

    modport master (
        output sound_in, mute, atten, signed_mode,
        input  audio_l, audio_r, sample_strobe, ramp_state
    );

    modport slave (
        input  sound_in, mute, atten, signed_mode,
        output audio_l, audio_r, sample_strobe, ramp_state
    );
endinterface

// File: rtl/gnw_audio_mixer.sv
// Decimating mixer for 1-bit sound sources: per-window duty-cycle measurement,
// channel averaging, attenuation and a gain ramp that fades in/out on mute.
module gnw_audio_mixer #(
    parameter int CHANNELS   = 1,
    parameter int DECIM_LOG2 = 11,
    parameter int RAMP_STEP  = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    gnw_audio_mixer_if.slave  bus
);
    localparam int CW        = DECIM_LOG2 + 1;
    localparam int CH_LOG2   = (CHANNELS == 4) ? 2 : ((CHANNELS == 2) ? 1 : 0);
    localparam int LVL_SHIFT = 14 - DECIM_LOG2;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    logic                  run_reg;
    logic [DECIM_LOG2-1:0] win_reg;
    logic                  win_end;
    logic [13:0]           level [CHANNELS];
    logic [15:0]           level_sum;
    logic [13:0]           mix;
    logic [13:0]           mix_att;
    logic [22:0]           u_prod;
    logic [15:0]           u_sample;
    logic signed [14:0]    s_cent;
    logic signed [14:0]    s_att;
    logic signed [24:0]    s_prod;
    logic [15:0]           s_sample;
    logic [15:0]           sample_next;
    logic [15:0]           audio_reg;
    logic                  strobe_reg;
    state_t                state_reg;
    state_t                state_next;
    logic [8:0]            gain_reg;
    logic [8:0]            gain_next;

    // run_reg holds off the first clock after reset so the first window starts one cycle late
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            run_reg <= 1'b0;
            win_reg <= '0;
        end else begin
            run_reg <= 1'b1;
            if (run_reg) begin
                win_reg <= win_reg + 1'b1;
            end
        end
    end

    assign win_end = run_reg && (&win_reg);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [CW-1:0] count_reg;
            logic [CW-1:0] count_final;
            logic [14:0]   level_full;

            // The closing cycle's input belongs to the window it closes
            assign count_final = count_reg + CW'(bus.sound_in[gi]);
            assign level_full  = 15'(count_final) << LVL_SHIFT;
            assign level[gi]   = level_full[14] ? 14'h3FFF : level_full[13:0];

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg <= '0;
                end else if (run_reg) begin
                    count_reg <= win_end ? '0 : count_final;
                end
            end
        end
    endgenerate

    always_comb begin
        level_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            level_sum = level_sum + 16'(level[i]);
        end
        mix = 14'(level_sum >> CH_LOG2);
    end

    assign mix_att  = mix >> bus.atten;
    assign u_prod   = 23'(mix_att) * 23'(gain_reg);
    assign u_sample = 16'(u_prod >> 8);

    // Signed path is centred on mid-scale before attenuation so silence fades to zero
    assign s_cent      = $signed({1'b0, mix}) - 15'sd8192;
    assign s_att       = s_cent >>> bus.atten;
    assign s_prod      = 25'(s_att) * $signed({16'd0, gain_reg});
    assign s_sample    = 16'(s_prod >>> 8);
    assign sample_next = bus.signed_mode ? s_sample : u_sample;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            audio_reg  <= '0;
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= win_end;
            if (win_end) begin
                audio_reg <= sample_next;
            end
        end
    end

    assign bus.audio_l       = audio_reg;
    assign bus.audio_r       = audio_reg;
    assign bus.sample_strobe = strobe_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= MUTED;
            gain_reg  <= '0;
        end else if (win_end) begin
            state_reg <= state_next;
            gain_reg  <= gain_next;
        end
    end

    // A direction change only flips the state; gain moves again from the following window
    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        case (state_reg)
            MUTED: begin
                gain_next = '0;
                if (!bus.mute) state_next = RAMP_UP;
            end
            RAMP_UP: begin
                if (bus.mute) begin
                    state_next = RAMP_DOWN;
                end else if (gain_reg >= 9'd256 - 9'(RAMP_STEP)) begin
                    gain_next  = 9'd256;
                    state_next = ACTIVE;
                end else begin
                    gain_next = gain_reg + 9'(RAMP_STEP);
                end
            end
            ACTIVE: begin
                gain_next = 9'd256;
                if (bus.mute) state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (!bus.mute) begin
                    state_next = RAMP_UP;
                end else if (gain_reg <= 9'(RAMP_STEP)) begin
                    gain_next  = '0;
                    state_next = MUTED;
                end else begin
                    gain_next = gain_reg - 9'(RAMP_STEP);
                end
            end
            default: begin
                state_next = MUTED;
                gain_next  = '0;
            end
        endcase
    end

    always_comb begin
        bus.ramp_state = state_reg;
    end
endmodule

// File: tb/tb_gnw_audio_mixer.sv
// Self-checking bench for gnw_audio_mixer: window-level reference model compared every
// cycle, plus hand-computed checkpoints for ramps, levels, latency and reset.
module tb_gnw_audio_mixer;
    localparam int CH    = 2;
    localparam int DLOG  = 4;
    localparam int DECIM = 1 << DLOG;
    localparam int STEP  = 1;

    localparam int P_RAND = 0;
    localparam int P_ONES = 1;
    localparam int P_CH0  = 2;
    localparam int P_SQ   = 3;
    localparam int P_ZERO = 4;

    logic clk_sys;
    logic reset_n;

    gnw_audio_mixer_if #(.CHANNELS(CH)) bus ();

    gnw_audio_mixer #(
        .CHANNELS  (CH),
        .DECIM_LOG2(DLOG),
        .RAMP_STEP (STEP)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, expv, expv, $time);
        end
    endtask

    // Reference model: windows counted from reset release, levels from duty cycle
    int          m_ticks = 0;
    int          m_acc [CH];
    int          m_gain  = 0;
    int          m_state = 0;
    logic [15:0] exp_audio  = '0;
    logic        exp_strobe = 1'b0;
    logic [1:0]  exp_state  = '0;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_ticks = 0;
            for (int c = 0; c < CH; c++) m_acc[c] = 0;
            m_gain     = 0;
            m_state    = 0;
            exp_audio  = '0;
            exp_strobe = 1'b0;
            exp_state  = '0;
        end else begin
            m_ticks++;
            exp_strobe = 1'b0;
            if (m_ticks >= 2) begin
                for (int c = 0; c < CH; c++) m_acc[c] += int'(bus.sound_in[c]);
                if ((m_ticks - 1) % DECIM == 0) begin
                    int mixv;
                    int lvl;
                    int att;
                    int v;
                    mixv = 0;
                    for (int c = 0; c < CH; c++) begin
                        lvl = (m_acc[c] * 16384) / DECIM;
                        if (lvl > 16383) lvl = 16383;
                        mixv += lvl;
                        m_acc[c] = 0;
                    end
                    mixv = mixv / CH;
                    att  = int'(bus.atten);
                    if (bus.signed_mode) begin
                        v = (mixv - 8192) >>> att;
                        v = (v * m_gain) >>> 8;
                    end else begin
                        v = ((mixv >> att) * m_gain) >> 8;
                    end
                    exp_audio  = 16'(v);
                    exp_strobe = 1'b1;
                    case (m_state)
                        0: begin
                            m_gain = 0;
                            if (!bus.mute) m_state = 1;
                        end
                        1: begin
                            if (bus.mute) m_state = 3;
                            else begin
                                m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
                                if (m_gain == 256) m_state = 2;
                            end
                        end
                        2: begin
                            m_gain = 256;
                            if (bus.mute) m_state = 3;
                        end
                        default: begin
                            if (!bus.mute) m_state = 1;
                            else begin
                                m_gain = (m_gain - STEP < 0) ? 0 : m_gain - STEP;
                                if (m_gain == 0) m_state = 0;
                            end
                        end
                    endcase
                    exp_state = 2'(m_state);
                end
            end
        end
    end

    always begin
        @(posedge clk_sys);
        #1;
        chk("cyc_audio_l", int'(bus.audio_l), int'(exp_audio));
        chk("cyc_audio_r", int'(bus.audio_r), int'(exp_audio));
        chk("cyc_strobe", int'(bus.sample_strobe), int'(exp_strobe));
        chk("cyc_state", int'(bus.ramp_state), int'(exp_state));
    end

    // Stimulus driver: one tick = one negedge; outputs captured before inputs change
    int   pattern = P_ONES;
    int   phase   = 0;
    logic s_strobe;
    int   s_audio;
    int   s_state;

    task automatic tick();
        @(negedge clk_sys);
        s_strobe = bus.sample_strobe;
        s_audio  = int'(bus.audio_l);
        s_state  = int'(bus.ramp_state);
        phase++;
        case (pattern)
            P_RAND:  bus.sound_in = 2'($urandom);
            P_ONES:  bus.sound_in = 2'b11;
            P_CH0:   bus.sound_in = 2'b01;
            P_SQ:    bus.sound_in = 2'(phase & 1);
            default: bus.sound_in = 2'b00;
        endcase
    endtask

    task automatic wait_sample(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_strobe && n < 3 * DECIM);
        if (!s_strobe) begin
            compared++;
            mismatched++;
            $display("FAIL strobe_timeout: no sample_strobe within %0d clocks at %0t", n, $time);
        end
    endtask

    initial begin
        int n;
        int k;
        bus.sound_in    = '0;
        bus.mute        = 1'b0;
        bus.atten       = 3'd0;
        bus.signed_mode = 1'b0;
        reset_n         = 1'b1;
        #3 reset_n = 1'b0;
        repeat (3) tick();
        chk("reset_audio", s_audio, 0);
        chk("reset_strobe", int'(s_strobe), 0);
        chk("reset_state", s_state, 0);

        reset_n = 1'b1;
        wait_sample(n);
        chk("first_strobe_latency", n, DECIM + 1);
        chk("first_sample", s_audio, 0);
        $display("sample 1: audio=%0d state=%0d", s_audio, s_state);

        for (int i = 2; i <= 258; i++) begin
            wait_sample(n);
            if (i == 257) begin
                chk("ramp_s257_audio", s_audio, 16319);
                chk("ramp_s257_state", s_state, 2);
                $display("sample 257: audio=%0d state=%0d", s_audio, s_state);
            end
            if (i == 258) begin
                chk("active_full_scale", s_audio, 16383);
                $display("sample 258: audio=%0d", s_audio);
            end
        end

        bus.atten = 3'd2;
        wait_sample(n);
        wait_sample(n);
        chk("atten2_level", s_audio, 4095);
        wait_sample(n);
        chk("strobe_period", n, DECIM);
        $display("atten=2: audio=%0d period=%0d", s_audio, n);

        bus.atten = 3'd0;
        pattern   = P_CH0;
        wait_sample(n);
        wait_sample(n);
        chk("ch0_only_level", s_audio, 8191);
        $display("ch0 only: audio=%0d", s_audio);
        pattern = P_SQ;
        wait_sample(n);
        wait_sample(n);
        chk("square_half_level", s_audio, 4096);
        $display("square: audio=%0d", s_audio);

        bus.signed_mode = 1'b1;
        pattern         = P_ONES;
        wait_sample(n);
        wait_sample(n);
        chk("signed_full", s_audio, 16'h1FFF);
        $display("signed ones: audio=0x%0h", s_audio);
        pattern = P_ZERO;
        wait_sample(n);
        wait_sample(n);
        chk("signed_zero_in", s_audio, 16'hE000);
        $display("signed zeros: audio=0x%0h", s_audio);

        bus.signed_mode = 1'b0;
        pattern         = P_ONES;
        wait_sample(n);
        bus.mute = 1'b1;
        wait_sample(n);
        chk("rampdown_start_state", s_state, 3);
        chk("rampdown_start_audio", s_audio, 16383);
        for (int i = 1; i <= 100; i++) wait_sample(n);
        bus.mute = 1'b0;
        wait_sample(n);
        chk("unmute_audio", s_audio, 9983);
        chk("unmute_state", s_state, 1);
        $display("unmute after 100: audio=%0d state=%0d", s_audio, s_state);
        for (int i = 0; i < 200 && s_state != 2; i++) wait_sample(n);
        chk("reactive_state", s_state, 2);

        bus.mute = 1'b1;
        wait_sample(n);
        k = 0;
        while (k < 300 && s_state != 0) begin
            wait_sample(n);
            k++;
        end
        chk("rampdown_length", k, 256);
        chk("rampdown_last_audio", s_audio, 63);
        $display("ramp-down: %0d samples, last audio=%0d", k, s_audio);
        wait_sample(n);
        chk("muted_unsigned", s_audio, 0);
        bus.signed_mode = 1'b1;
        wait_sample(n);
        wait_sample(n);
        chk("muted_signed", s_audio, 0);
        $display("muted signed: audio=0x%0h", s_audio);

        repeat (4) tick();
        bus.mute = 1'b0;
        repeat (3) tick();
        bus.mute = 1'b1;
        wait_sample(n);
        chk("mute_pulse_ignored", s_state, 0);
        $display("short unmute pulse: state=%0d", s_state);

        bus.signed_mode = 1'b0;
        bus.mute        = 1'b0;
        repeat (20) wait_sample(n);
        chk("pre_reset_rampup", s_state, 1);
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_audio_l", int'(bus.audio_l), 0);
        chk("async_reset_audio_r", int'(bus.audio_r), 0);
        chk("async_reset_strobe", int'(bus.sample_strobe), 0);
        chk("async_reset_state", int'(bus.ramp_state), 0);
        tick();
        reset_n = 1'b1;
        wait_sample(n);
        chk("post_reset_latency", n, DECIM + 1);
        chk("post_reset_sample", s_audio, 0);
        $display("after mid-ramp reset: latency=%0d audio=%0d", n, s_audio);

        pattern = P_RAND;
        for (int i = 0; i < 60; i++) begin
            wait_sample(n);
            $display("random sample %0d: audio=0x%0h state=%0d", i, s_audio, s_state);
            bus.atten       = 3'($urandom);
            bus.signed_mode = 1'($urandom);
            if ($urandom_range(0, 3) == 0) bus.mute = ~bus.mute;
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
